// File: rtl/rate_enb_pkg.sv
// Shared types and helpers for the multi-rate clock-enable generator.
//   rate_mode_t  : per-channel operating mode (periodic / one-shot)
//   rate_state_t : per-channel FSM state (idle / run)
//   hz_to_div()  : converts a clock frequency and a target rate into a divisor
//                  expressed in clock cycles per enable, never less than 1.
package rate_enb_pkg;

    typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} rate_mode_t;
    typedef enum logic {ST_IDLE, ST_RUN} rate_state_t;

    // A zero rate would divide by zero; treat it as "one pulse per clkfreq cycles".
    function automatic int unsigned hz_to_div(input int unsigned clkfreq, input int unsigned hz);
        int unsigned d;
        d = (hz == 0) ? clkfreq : clkfreq / hz;
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/rate_enb_chan.sv
// One channel of the multi-rate enable generator: divisor register, cycle
// counter and IDLE/RUN FSM.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : counter clear (FSM state kept)
//   en        : run enable used in periodic mode
//   start     : trigger used in one-shot mode (ignored while running)
//   mode      : 0 = periodic, 1 = one-shot
//   div_we    : load div_val into the divisor and clear the counter
//   div_val   : new divisor in clock cycles per enable
//   enb       : single-cycle enable pulse
//   busy      : channel is in RUN
module rate_enb_chan
    import rate_enb_pkg::*;
#(
    parameter int unsigned     CNTW    = 32,
    parameter logic [CNTW-1:0] DIV_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic            start,
    input  logic            mode,
    input  logic            div_we,
    input  logic [CNTW-1:0] div_val,
    output logic            enb,
    output logic            busy
);

    rate_state_t     state_q, state_d;
    logic [CNTW-1:0] div_q, div_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] div_eff;
    logic            term;
    rate_mode_t      mode_t;

    assign mode_t  = rate_mode_t'(mode);
    // 0 and 1 both mean "every cycle".
    assign div_eff = (div_q <= CNTW'(1)) ? CNTW'(1) : div_q;
    assign term    = (cnt_q == div_eff - CNTW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((mode_t == MODE_PERIODIC && en) || (mode_t == MODE_ONESHOT && start))
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mode_t == MODE_PERIODIC && !en)
                    state_d = ST_IDLE;
                else if (mode_t == MODE_ONESHOT && enb)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: purely from registers
    always_comb begin
        busy = (state_q == ST_RUN);
        enb  = busy && term;
    end

    // Counter and divisor datapath. The cycle in which the channel enters RUN
    // already counts as q=0, so the counter advances on entry too; with a
    // divisor of 1 that entry step wraps straight back to 0.
    always_comb begin
        div_d = div_we ? div_val : div_q;
        if (div_we || clr)
            cnt_d = '0;
        else if (state_d == ST_IDLE)
            cnt_d = '0;
        else if (term)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNTW'(1);
    end

endmodule

// File: rtl/multi_rate_enb.sv
// Multi-channel clock-enable generator. NCH independent channels each emit a
// single-cycle enable every "divisor" cycles of clk, periodic or one-shot.
// Optional feature (macro MULTI_RATE_ENB_SYNC_EN): adds sync_in, which clears
// the counters of all running channels in the same edge to phase-align them.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr/en/start/mode [NCH] : per-channel controls
//   div_we, div_ch, div_val : divisor write port (div_ch >= NCH is ignored)
//   sync_in         : (MULTI_RATE_ENB_SYNC_EN only) global counter phase-align
//   enb_out [NCH]   : per-channel enable pulses
//   busy    [NCH]   : per-channel RUN indicator
module multi_rate_enb
    import rate_enb_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CLKFREQ    = 100_000_000,
    parameter int unsigned DEFAULT_HZ = 1000,
    parameter int unsigned CNTW       = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NCH-1:0]                        clr,
    input  logic [NCH-1:0]                        en,
    input  logic [NCH-1:0]                        start,
    input  logic [NCH-1:0]                        mode,
    input  logic                                  div_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] div_ch,
    input  logic [CNTW-1:0]                       div_val,
`ifdef MULTI_RATE_ENB_SYNC_EN
    input  logic                                  sync_in,
`endif
    output logic [NCH-1:0]                        enb_out,
    output logic [NCH-1:0]                        busy
);

    localparam int unsigned     CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNTW-1:0] DIV_RST = CNTW'(hz_to_div(CLKFREQ, DEFAULT_HZ));

    logic [NCH-1:0] div_sel;
    logic [NCH-1:0] clr_eff;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            // Out-of-range div_ch never matches any channel index.
            assign div_sel[gi] = div_we && (div_ch == CHW'(gi));
`ifdef MULTI_RATE_ENB_SYNC_EN
            // Only running channels are re-phased; idle ones already sit at 0.
            assign clr_eff[gi] = clr[gi] | (sync_in & busy[gi]);
`else
            assign clr_eff[gi] = clr[gi];
`endif
            rate_enb_chan #(
                .CNTW    (CNTW),
                .DIV_RST (DIV_RST)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr_eff[gi]),
                .en      (en[gi]),
                .start   (start[gi]),
                .mode    (mode[gi]),
                .div_we  (div_sel[gi]),
                .div_val (div_val),
                .enb     (enb_out[gi]),
                .busy    (busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_rate_enb.sv
// Testbench for multi_rate_enb: directed scenarios followed by random stimulus,
// all checked against a timestamp-based reference model (each running channel
// remembers the cycle its count origin sits at; a pulse is due whenever the
// elapsed time modulo the divisor reaches divisor-1).
module tb_multi_rate_enb;

    localparam int NCH        = 3;
    localparam int CNTW       = 32;
    localparam int CLKFREQ    = 1000;
    localparam int DEFAULT_HZ = 100;
    localparam int DEF_DIV    = CLKFREQ / DEFAULT_HZ;
    localparam int CHW        = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   clr, en, start, mode;
    logic             div_we;
    logic [CHW-1:0]   div_ch;
    logic [CNTW-1:0]  div_val;
    logic             sync_in;
    logic [NCH-1:0]   enb_out, busy;

    always #5 clk = ~clk;

    multi_rate_enb #(
        .NCH        (NCH),
        .CLKFREQ    (CLKFREQ),
        .DEFAULT_HZ (DEFAULT_HZ),
        .CNTW       (CNTW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .start   (start),
        .mode    (mode),
        .div_we  (div_we),
        .div_ch  (div_ch),
        .div_val (div_val),
`ifdef MULTI_RATE_ENB_SYNC_EN
        .sync_in (sync_in),
`endif
        .enb_out (enb_out),
        .busy    (busy)
    );

    int     checks = 0;
    int     errors = 0;
    longint n      = 0;

    // Reference model state
    bit          m_run [NCH];
    longint      m_t0  [NCH];
    int unsigned m_div [NCH];

    task automatic chk(input string tag, input int idx, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] at cycle %0d: got %b expected %b", tag, idx, n, got, exp);
        end
    endtask

    function automatic logic exp_enb(input int c);
        longint d;
        d = longint'(m_div[c]);
        return m_run[c] && (((n - m_t0[c]) % d) == d - 1);
    endfunction

    // Advance the model across one clock edge using the inputs of cycle n.
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            logic pulse, was, wr, clear;
            pulse = exp_enb(c);
            was   = m_run[c];
            if (rst) begin
                m_run[c] = 1'b0;
                m_t0[c]  = n + 1;
                m_div[c] = DEF_DIV;
            end else begin
                wr    = div_we && (int'(div_ch) == c);
                clear = clr[c] || wr || (sync_in && was);
                if (!was) begin
                    if ((!mode[c] && en[c]) || (mode[c] && start[c])) begin
                        m_run[c] = 1'b1;
                        m_t0[c]  = clear ? n + 1 : n;
                    end
                end else begin
                    if (!mode[c] && !en[c])
                        m_run[c] = 1'b0;
                    else if (mode[c] && pulse)
                        m_run[c] = 1'b0;
                    if (clear)
                        m_t0[c] = n + 1;
                end
                if (wr)
                    m_div[c] = (div_val < 2) ? 1 : int'(div_val);
            end
        end
    endtask

    // One clock cycle: compare outputs with the model, log, step model and DUT.
    task automatic cyc();
        for (int c = 0; c < NCH; c++) begin
            chk("busy", c, busy[c], m_run[c]);
            chk("enb_out", c, enb_out[c], exp_enb(c));
        end
        if (rst || div_we || (start != '0) || (clr != '0) || sync_in)
            $display("cycle %0d: rst=%b en=%b mode=%b start=%b clr=%b div_we=%b ch=%0d val=%0d sync=%b enb=%b busy=%b",
                     n, rst, en, mode, start, clr, div_we, div_ch, div_val, sync_in, enb_out, busy);
        model_step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic quiet();
        clr = '0; start = '0; div_we = 1'b0; div_ch = '0; div_val = '0; sync_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0;
        quiet();
        // First reset edge: DUT registers are unknown before it, so no checks.
        model_step();
        @(posedge clk);
        @(negedge clk);
        n++;

        // Reset state
        chk("rst_busy", 0, busy == '0, 1'b1);
        chk("rst_enb", 0, enb_out == '0, 1'b1);
        cyc();

        // 1: default divisor 10, pulses at 9, 19, 29
        rst = 1'b0;
        en  = 3'b001;
        for (int k = 0; k < 30; k++) begin
            chk("t1_enb0", 0, enb_out[0], (k == 9 || k == 19 || k == 29));
            chk("t1_other", 0, enb_out[2:1] == 2'b00, 1'b1);
            cyc();
        end
        en = '0;
        cyc();

        // 2: one-shot on ch1, div 4, start at 5, retrigger at 7 ignored
        mode = 3'b010;
        for (int k = 0; k < 13; k++) begin
            div_we = (k == 0); div_ch = 2'd1; div_val = 4;
            start  = (k == 5 || k == 7) ? 3'b010 : 3'b000;
            chk("t2_enb1", 1, enb_out[1], (k == 8));
            chk("t2_busy1", 1, busy[1], (k >= 6 && k <= 8));
            cyc();
        end
        quiet();

        // 3: ch2 divisor rewritten to 3 at q=6; write to channel 3 (absent) ignored
        en = 3'b100;
        for (int k = 0; k < 17; k++) begin
            div_we  = (k == 6 || k == 10);
            div_ch  = (k == 10) ? 2'd3 : 2'd2;
            div_val = (k == 10) ? 7 : 3;
            chk("t3_enb2", 2, enb_out[2], (k == 9 || k == 12 || k == 15));
            cyc();
        end
        quiet();

        // 4: clamp, divisor 0 then 1 on ch0 -> every cycle
        for (int k = 0; k < 9; k++) begin
            div_we  = (k == 0 || k == 5); div_ch = 2'd0;
            div_val = (k == 0) ? 0 : 1;
            en[0]   = (k >= 1);
            chk("t4_enb0", 0, enb_out[0], (k >= 2));
            cyc();
        end
        quiet();
        en[0] = 1'b0;
        cyc();

        // 5: clr mid-count and clr on terminal count, ch1 periodic div 10
        mode = '0;
        for (int k = 0; k < 27; k++) begin
            div_we = (k == 0); div_ch = 2'd1; div_val = 10;
            en[1]  = (k >= 1);
            clr    = (k == 5 || k == 15) ? 3'b010 : 3'b000;
            chk("t5_enb1", 1, enb_out[1], (k == 15 || k == 25));
            cyc();
        end
        quiet();

        // 5b: rst mid-run, then divisors back to default
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        en  = 3'b100;
        for (int k = 0; k < 11; k++) begin
            if (k == 0) begin
                chk("t5_rst_busy", 0, busy == '0, 1'b1);
                chk("t5_rst_enb", 0, enb_out == '0, 1'b1);
            end
            chk("t5_def_enb2", 2, enb_out[2], (k == 9));
            cyc();
        end
        en = '0;
        cyc();

`ifdef MULTI_RATE_ENB_SYNC_EN
        // 6: sync_in phase-aligns ch0 (div 10) and ch1 (div 5)
        for (int k = 0; k < 19; k++) begin
            div_we  = (k == 0); div_ch = 2'd1; div_val = 5;
            en[0]   = 1'b1;
            en[1]   = (k >= 3);
            sync_in = (k == 7);
            chk("t6_enb0", 0, enb_out[0], (k == 17));
            chk("t6_enb1", 1, enb_out[1], (k == 7 || k == 12 || k == 17));
            cyc();
        end
        quiet();
        en = '0;
        cyc();
`endif

        // Random phase
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) en = NCH'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) mode = NCH'($urandom_range(0, 7));
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(0, 7) == 0);
                clr[c]   = ($urandom_range(0, 31) == 0);
            end
            div_we  = ($urandom_range(0, 11) == 0);
            div_ch  = CHW'($urandom_range(0, 3));
            div_val = CNTW'($urandom_range(0, 7));
`ifdef MULTI_RATE_ENB_SYNC_EN
            sync_in = ($urandom_range(0, 39) == 0);
`endif
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_rate_enb.md
Name: multi_rate_enb

Overview:
Multi-channel clock-enable generator. Each channel emits a single-cycle enable at its own divisor rate, programmable at run time. Each channel runs periodic or one-shot. Sits beside the system clock domain and drives debouncers, display scanners, timers and UART baud ticks from one common clock. Every flop is clocked by clk; no clock division.

Parameters:
NCH, 4, number of independent channels (1..16)
CLKFREQ, 100_000_000, system clock frequency in Hz
DEFAULT_HZ, 1000, rate loaded into every channel at reset
CNTW, 32, width of divisor registers and counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high master reset
clr  input  NCH  per-channel synchronous counter clear; state unchanged
en  input  NCH  per-channel run enable, periodic mode
start  input  NCH  per-channel one-shot trigger pulse
mode  input  NCH  per-channel mode: 0 = periodic, 1 = one-shot
div_we  input  1  divisor write strobe
div_ch  input  $clog2(NCH) (min 1)  channel selected by div_we
div_val  input  CNTW  new divisor, in clock cycles per enable
enb_out  output  NCH  per-channel single-cycle enable pulse
busy  output  NCH  channel in RUN state

Behaviour:
- Reset:
  - Every divisor = CLKFREQ/DEFAULT_HZ.
  - All counters = 0; all channels IDLE.
  - enb_out = 0 and busy = 0.
- Per-channel FSM:
  - IDLE -> RUN when mode=0 and en=1.
  - IDLE -> RUN when mode=1 and start=1.
  - RUN -> IDLE when mode=0 and en=0; counter cleared.
  - RUN -> IDLE when mode=1 in the cycle enb_out fires.
  - start is ignored in RUN (no retrigger).
- Counting:
  - In RUN, the counter increments each cycle.
  - enb_out = busy && (q == div-1). This is combinational from registers; no input-to-output path.
  - The counter wraps to 0 in the cycle enb_out is high.
  - The first pulse arrives div cycles after entering RUN. The entering cycle counts as q=0.
- Divisor:
  - A stored value of 0 or 1 is clamped to 1, giving enb_out every cycle while in RUN.
  - div_we writes div_val into channel div_ch and clears that channel's counter in the same edge. State is kept.
  - A div_ch value >= NCH is ignored.
- Priority per channel, highest first: rst > div_we counter clear = clr > terminal count > increment.
  - clr coincident with terminal count: enb_out still asserts that cycle (it is combinational), then q = 0.
  - In one-shot mode, clr does not abort the shot; the shot restarts its count.
- Mode change while in RUN takes effect immediately using the current FSM rules.
- Channels are fully independent. Simultaneous pulses on several channels are legal.

Optional Feature:
Macro MULTI_RATE_ENB_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 clears the counters of all RUN channels in the same edge, phase-aligning them. Priority equals clr.
  - enb_out is not suppressed in the sync cycle.
- Undefined:
  - No sync_in port; channels free-run independently.

Decomposition:
- Package rate_enb_pkg holds:
  - typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} rate_mode_t.
  - typedef enum logic {ST_IDLE, ST_RUN} rate_state_t.
  - Function hz_to_div(clkfreq, hz), returning at least 1.
- Sub-module rate_enb_chan implements one channel: divisor register, counter and FSM.
- The top level instantiates NCH copies via generate and decodes div_we/div_ch.

Test Plan:
1. Reset pulse default: CLKFREQ=1000, DEFAULT_HZ=100, en[0]=1 from cycle 0 -> enb_out[0] high at cycles 9, 19, 29; busy[0]=1; other channels stay 0.
2. One-shot: mode[1]=1, start[1] pulsed at cycle 5 with div=4 -> single enb_out[1] at cycle 8, busy[1] falls at cycle 9; start pulses during RUN are ignored.
3. Divisor write: write div_val=3 to ch2 mid-count (q=6 of 10) -> q=0 next cycle, pulses every 3 cycles after.
4. Divisor clamp: write div_val=0 and then 1 -> enb_out high every cycle while en=1.
5. Priorities: clr with terminal count gives a pulse that cycle, then next pulse div cycles later. rst mid-run gives all outputs 0 the next cycle and divisors back to default.
6. SYNC_EN: ch0 div=10 and ch1 div=5 at offset phases, sync_in pulse -> both pulse together 5 cycles after sync (ch1) and ch0 at 10. Without the macro, the sync_in port is absent.
